// File: rtl/reg_file_2r1w_if.sv
// Request/response bundle for reg_file_2r1w: clear, write port and two read ports.
// The master (decode side) drives requests; the slave (register file) returns read data.
interface reg_file_2r1w_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  clear;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable_a;
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic                  read_valid_a;
    logic                  read_enable_b;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic                  read_valid_b;

    modport master (
        output clear, write_enable, write_addr, write_data,
        output read_enable_a, read_addr_a, read_enable_b, read_addr_b,
        input  read_data_a, read_valid_a, read_data_b, read_valid_b
    );

    modport slave (
        input  clear, write_enable, write_addr, write_data,
        input  read_enable_a, read_addr_a, read_enable_b, read_addr_b,
        output read_data_a, read_valid_a, read_data_b, read_valid_b
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with registered read ports, synchronous clear and an
// optional hardwired-zero entry 0. Define REG_FILE_WR_BYPASS_EN for write-first collisions.
module reg_file_2r1w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1
) (
    input logic           clock,
    input logic           reset,
    reg_file_2r1w_if.slave bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    data_t      mem_q [NUM_REGS];
    data_t      mem_d [NUM_REGS];
    data_t      rdata_q [2];
    data_t      rdata_d [2];
    logic [1:0] rvalid_q;
    logic [1:0] rvalid_d;
    addr_t      raddr [2];
    logic [1:0] ren;
    logic       write_ok;

    assign raddr[0] = bus.read_addr_a;
    assign raddr[1] = bus.read_addr_b;
    assign ren      = {bus.read_enable_b, bus.read_enable_a};

    // Writes to the hardwired-zero entry are dropped rather than stored.
    assign write_ok = bus.write_enable && !(ZERO_REG && (bus.write_addr == '0));

    always_comb begin
        mem_d = mem_q;
        if (bus.clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_d[i] = '0;
            end
        end else if (write_ok) begin
            mem_d[bus.write_addr] = bus.write_data;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rvalid_d[p] = ren[p];
            rdata_d[p]  = rdata_q[p];
            if (ren[p]) begin
                if (ZERO_REG && (raddr[p] == '0)) begin
                    rdata_d[p] = '0;
`ifdef REG_FILE_WR_BYPASS_EN
                // Clear is never forwarded: a read alongside clear sees pre-clear contents.
                end else if (write_ok && !bus.clear && (bus.write_addr == raddr[p])) begin
                    rdata_d[p] = bus.write_data;
`endif
                end else begin
                    rdata_d[p] = mem_q[raddr[p]];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            rvalid_q   <= '0;
        end else begin
            mem_q      <= mem_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
            rvalid_q   <= rvalid_d;
        end
    end

    assign bus.read_data_a  = rdata_q[0];
    assign bus.read_valid_a = rvalid_q[0];
    assign bus.read_data_b  = rdata_q[1];
    assign bus.read_valid_b = rvalid_q[1];
endmodule
